// File: rtl/fc_argmax_if.sv
// Score-stream and result bus between a score source and the fc_argmax block.
interface fc_argmax_if #(
  parameter int BIT   = 32,
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic [BIT-1:0]   in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [IDX_W-1:0] class_idx;
  logic [BIT-1:0]   max_score;
  logic             frame_err;

  // Score source / result consumer side
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, class_idx, max_score, frame_err
  );

  // Argmax block side
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, class_idx, max_score, frame_err
  );
endinterface

// File: rtl/fc_argmax.sv
// Streaming argmax over NUM_CLASS IEEE-754 single-precision scores per frame.
// One score per cycle; result presented for one cycle in DONE and held afterwards.
module fc_argmax #(
  parameter int BIT       = 32,
  parameter int NUM_CLASS = 7,
  parameter int IDX_W     = 4
) (
  input logic        clk,
  input logic        rst_,
  fc_argmax_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_CLASS + 1);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_count, w_count_d, w_count_inc;
  logic [BIT-1:0]   r_max, w_max_d;
  logic [IDX_W-1:0] r_idx, w_idx_d;
  logic [BIT-1:0]   r_max_score, w_max_score_d;
  logic [IDX_W-1:0] r_class_idx, w_class_idx_d;
  logic             r_frame_err, w_frame_err_d;

  logic             w_xfer;
  logic             w_nan_new, w_nan_max;
  logic [BIT-1:0]   w_key_new, w_key_max;
  logic             w_gt;
  logic [BIT-1:0]   w_sel_max;
  logic [IDX_W-1:0] w_sel_idx;

  // NaN: exponent all ones with a nonzero mantissa
  function automatic logic f_is_nan(input logic [BIT-1:0] v);
    return (&v[BIT-2:BIT-9]) && (|v[BIT-10:0]);
  endfunction

  // Map a float to an unsigned key whose integer order matches IEEE order.
  // Both zeros map to the same key so +0 and -0 tie.
  function automatic logic [BIT-1:0] f_key(input logic [BIT-1:0] v);
    logic [BIT-1:0] k;
    if (v[BIT-2:0] == '0) begin
      k = {1'b1, {(BIT-1){1'b0}}};
    end else if (v[BIT-1]) begin
      k = ~v;
    end else begin
      k = {1'b1, v[BIT-2:0]};
    end
    return k;
  endfunction

  // Combinational strictly-greater comparator between incoming score and running max
  always_comb begin
    w_nan_new = f_is_nan(bus.in_data);
    w_nan_max = f_is_nan(r_max);
    w_key_new = f_key(bus.in_data);
    w_key_max = f_key(r_max);
    // A NaN never wins; a NaN running max loses to any real score
    w_gt      = !w_nan_new && (w_nan_max || (w_key_new > w_key_max));
    w_sel_max = w_gt ? bus.in_data : r_max;
    w_sel_idx = w_gt ? IDX_W'(r_count) : r_idx;
  end

  assign w_xfer      = bus.in_valid && bus.in_ready;
  assign w_count_inc = r_count + CNT_W'(1);

  // Next-state, running max/index and result-capture logic
  always_comb begin
    w_state_d     = r_state;
    w_count_d     = r_count;
    w_max_d       = r_max;
    w_idx_d       = r_idx;
    w_max_score_d = r_max_score;
    w_class_idx_d = r_class_idx;
    w_frame_err_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_max_d = bus.in_data;
          w_idx_d = '0;
          if (bus.in_last) begin
            // Frame of one score is always short
            w_frame_err_d = 1'b1;
            w_count_d     = '0;
          end else begin
            w_count_d = CNT_W'(1);
            w_state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (w_xfer) begin
          w_max_d = w_sel_max;
          w_idx_d = w_sel_idx;
          if (w_count_inc == CNT_W'(NUM_CLASS)) begin
            // Frame length decides completion; in_last is not required here
            w_count_d     = w_count_inc;
            w_max_score_d = w_sel_max;
            w_class_idx_d = w_sel_idx;
            w_state_d     = StDone;
          end else if (bus.in_last) begin
            w_frame_err_d = 1'b1;
            w_count_d     = '0;
            w_state_d     = StIdle;
          end else begin
            w_count_d = w_count_inc;
          end
        end
      end
      StDone: begin
        w_count_d = '0;
        w_state_d = StIdle;
      end
      default: begin
        w_count_d = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_max       <= '0;
      r_idx       <= '0;
      r_max_score <= '0;
      r_class_idx <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_count     <= w_count_d;
      r_max       <= w_max_d;
      r_idx       <= w_idx_d;
      r_max_score <= w_max_score_d;
      r_class_idx <= w_class_idx_d;
      r_frame_err <= w_frame_err_d;
    end
  end

  assign bus.in_ready  = (r_state != StDone);
  assign bus.out_valid = (r_state == StDone);
  assign bus.class_idx = r_class_idx;
  assign bus.max_score = r_max_score;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: driver pushes expected results, monitor pops on output pulses.
module tb_fc_argmax;

  localparam int BIT       = 32;
  localparam int NUM_CLASS = 7;
  localparam int IDX_W     = 4;

  logic clk = 1'b0;
  logic rst_ = 1'b0;

  always #5 clk = ~clk;

  fc_argmax_if #(.BIT(BIT), .IDX_W(IDX_W)) bus ();

  fc_argmax #(
    .BIT      (BIT),
    .NUM_CLASS(NUM_CLASS),
    .IDX_W    (IDX_W)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  typedef struct {
    bit               err;
    logic [IDX_W-1:0] idx;
    logic [BIT-1:0]   score;
  } exp_t;

  typedef logic [BIT-1:0] frame_t [7];

  exp_t             q[$];
  exp_t             m_e;
  int               n_vec = 0;
  int               n_miss = 0;
  int               cyc = 0;
  int               last_acc_cyc = 0;
  logic [IDX_W-1:0] held_idx = '0;
  logic [BIT-1:0]   held_score = '0;
  bit               win = 1'b0;
  int               ready_low = 0;
  frame_t           f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result or error pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (win && !bus.in_ready) ready_low++;
    if (rst_ && (bus.out_valid || bus.frame_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {30'b0, bus.out_valid, bus.frame_err}, 32'h0);
      end else begin
        m_e = q.pop_front();
        chk("out_valid", 32'(bus.out_valid), 32'(!m_e.err));
        chk("frame_err", 32'(bus.frame_err), 32'(m_e.err));
        chk("class_idx", 32'(bus.class_idx), 32'(m_e.idx));
        chk("max_score", bus.max_score, m_e.score);
        chk("latency", 32'(cyc), 32'(last_acc_cyc + 1));
      end
    end
  end

  // Present one word until accepted; caller is positioned just after a rising edge
  task automatic send_word(input logic [BIT-1:0] d, input bit last, input bit fin);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc && fin) last_acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'h1);
  endtask

  task automatic send_frame(input frame_t fr, input int n, input int last_at, input bit err,
                            input int idx, input logic [BIT-1:0] score);
    exp_t e;
    e.err = err;
    if (err) begin
      e.idx   = held_idx;
      e.score = held_score;
    end else begin
      e.idx      = IDX_W'(idx);
      e.score    = score;
      held_idx   = e.idx;
      held_score = score;
    end
    q.push_back(e);
    for (int i = 0; i < n; i++) send_word(fr[i], (i == last_at), (i == n - 1));
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_class_idx", 32'(bus.class_idx), 32'h0);
    chk("rst_max_score", bus.max_score, 32'h0);
    rst_ = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Basic frame, max 5.0 at index 2
    f = '{32'h3F800000, 32'h40000000, 32'h40A00000, 32'h40400000,
          32'hBF800000, 32'h3F000000, 32'h40800000};
    send_frame(f, 7, 6, 1'b0, 2, 32'h40A00000);
    idle(3);

    // All equal: lowest index wins
    f = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
          32'h40000000, 32'h40000000, 32'h40000000};
    send_frame(f, 7, 6, 1'b0, 0, 32'h40000000);
    idle(2);

    // +0 at index 0 ties with later -0
    f = '{32'h00000000, 32'h80000000, 32'hBF800000, 32'hC0000000,
          32'h80000000, 32'hC0400000, 32'hBF000000};
    send_frame(f, 7, 6, 1'b0, 0, 32'h00000000);
    idle(2);

    // NaN at index 0 replaced; max -0.5 at index 5
    f = '{32'h7FC00000, 32'hC0400000, 32'hC0000000, 32'hC0400000,
          32'hC0000000, 32'hBF000000, 32'hC0400000};
    send_frame(f, 7, 6, 1'b0, 5, 32'hBF000000);
    idle(2);

    // Short frame: in_last on 4th score; result registers must hold
    f = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
          32'h0, 32'h0, 32'h0};
    send_frame(f, 4, 3, 1'b1, 0, 32'h0);
    idle(2);

    // Infinities and NaN after a short frame
    f = '{32'h00000001, 32'h00000010, 32'hFF800000, 32'h7F800000,
          32'h7F800000, 32'h7FC00000, 32'h40000000};
    send_frame(f, 7, 6, 1'b0, 3, 32'h7F800000);
    idle(2);

    // Denormals by magnitude, negative NaN, tie at index 6
    f = '{32'h80000001, 32'h80000002, 32'h00000003, 32'h00000002,
          32'hFFC00000, 32'h80000005, 32'h00000003};
    send_frame(f, 7, 6, 1'b0, 2, 32'h00000003);
    idle(2);

    // Two frames with in_valid held high throughout
    win = 1'b1;
    f = '{32'hC1200000, 32'hC1100000, 32'hC1300000, 32'hC0E00000,
          32'hC1000000, 32'hC1400000, 32'hC1500000};
    send_frame(f, 7, 6, 1'b0, 3, 32'hC0E00000);
    f = '{32'h41200000, 32'h41200000, 32'h41300000, 32'h41100000,
          32'h41300000, 32'h3F800000, 32'h00000000};
    send_frame(f, 7, 6, 1'b0, 2, 32'h41300000);
    idle(3);
    win = 1'b0;
    chk("ready_low_cycles", 32'(ready_low), 32'h2);

    // Reset after three scores of a partial frame
    send_word(32'h7F800000, 1'b0, 1'b0);
    send_word(32'h7F800000, 1'b0, 1'b0);
    send_word(32'h7F800000, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_ = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_class_idx", 32'(bus.class_idx), 32'h0);
    chk("mid_rst_max_score", bus.max_score, 32'h0);
    rst_ = 1'b1;
    held_idx   = '0;
    held_score = '0;
    @(posedge clk);
    #1;

    // Full frame without in_last completes normally
    f = '{32'h3F000000, 32'h3E800000, 32'h3F400000, 32'h3F400000,
          32'h3E000000, 32'h3F3FFFFF, 32'h00800000};
    send_frame(f, 7, -1, 1'b0, 2, 32'h3F400000);
    idle(5);

    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
